// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
package fetch_decode_queue_pkg;

    // Widest PC/immediate and instruction the queue entry can carry.
    localparam int unsigned ENTRY_XLEN = 64;
    localparam int unsigned ENTRY_ILEN = 32;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef struct packed {
        logic [ENTRY_ILEN-1:0] instruction;
        logic [ENTRY_XLEN-1:0] immediate;
        logic [ENTRY_XLEN-1:0] pc;
        logic                  is_branch;
        logic                  illegal;
    } qentry_t;

    // Conditional branches share a single major opcode.
    function automatic logic is_branch_op(input logic [6:0] opcode);
        return opcode == OPC_BRANCH;
    endfunction

    // Only 32-bit encodings (low bits 2'b11) are supported.
    function automatic logic is_illegal_enc(input logic [1:0] low_bits);
        return low_bits != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_mem.sv
// Entry storage: DEPTH registers, one write port, one asynchronous read port.
module fetch_decode_queue_mem
    import fetch_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  qentry_t       wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output qentry_t       rd_data_o
);

    qentry_t mem_q [DEPTH];

    // Storage is never reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic in-order queue between fetch and decode, with enqueue-time tagging
// of branches and illegal encodings and a synchronous flush for redirects.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ILEN-1:0]          in_instruction,
    input  logic [XLEN-1:0]          in_immediate,
    input  logic [XLEN-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ILEN-1:0]          out_instruction,
    output logic [XLEN-1:0]          out_immediate,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_is_branch,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic    enq, deq;
    qentry_t wr_entry;
    qentry_t rd_entry;

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = count_q;

    // Pack the incoming fetch bundle and compute its tags once, at enqueue.
    always_comb begin
        wr_entry             = '0;
        wr_entry.instruction = ENTRY_ILEN'(in_instruction);
        wr_entry.immediate   = ENTRY_XLEN'(in_immediate);
        wr_entry.pc          = ENTRY_XLEN'(in_pc);
        wr_entry.is_branch   = is_branch_op(in_instruction[6:0]);
        wr_entry.illegal     = is_illegal_enc(in_instruction[1:0]);
    end

    fetch_decode_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (enq),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    // Pointer and occupancy next state; flush overrides any handshake.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers; reset empties the queue at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head entry while valid, otherwise a NOP bundle so decode sees no side effects.
    always_comb begin
        out_instruction = ILEN'(NOP_INSTR);
        out_immediate   = '0;
        out_pc          = '0;
        out_is_branch   = 1'b0;
        out_illegal     = 1'b0;
        if (out_valid) begin
            out_instruction = rd_entry.instruction[ILEN-1:0];
            out_immediate   = rd_entry.immediate[XLEN-1:0];
            out_pc          = rd_entry.pc[XLEN-1:0];
            out_is_branch   = rd_entry.is_branch;
            out_illegal     = rd_entry.illegal;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised and directed bench for fetch_decode_queue against a queue model.
module tb_fetch_decode_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] in_instruction;
    logic [XLEN-1:0] in_immediate;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instruction;
    logic [XLEN-1:0] out_immediate;
    logic [XLEN-1:0] out_pc;
    logic            out_is_branch;
    logic            out_illegal;
    logic [CW-1:0]   count;

    fetch_decode_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ILEN  (ILEN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_immediate    (in_immediate),
        .in_pc           (in_pc),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_immediate   (out_immediate),
        .out_pc          (out_pc),
        .out_is_branch   (out_is_branch),
        .out_illegal     (out_illegal),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [63:0] pc;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_all(input string tag);
        ent_t h;
        check_eq({tag, ".count"}, 64'(count), 64'(mq.size()));
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
        if (mq.size() != 0) begin
            h = mq[0];
            check_eq({tag, ".instr"}, 64'(out_instruction), 64'(h.ins));
            check_eq({tag, ".imm"}, out_immediate, h.imm);
            check_eq({tag, ".pc"}, out_pc, h.pc);
            check_eq({tag, ".branch"}, 64'(out_is_branch), 64'(h.ins[6:0] == 7'h63));
            check_eq({tag, ".illegal"}, 64'(out_illegal), 64'(h.ins[1:0] != 2'b11));
        end else begin
            check_eq({tag, ".instr"}, 64'(out_instruction), 64'h13);
            check_eq({tag, ".imm"}, out_immediate, 64'h0);
            check_eq({tag, ".pc"}, out_pc, 64'h0);
            check_eq({tag, ".branch"}, 64'(out_is_branch), 64'h0);
            check_eq({tag, ".illegal"}, 64'(out_illegal), 64'h0);
        end
    endtask

    // One clock: model the edge from the currently driven inputs, then check.
    task automatic cycle(input string tag);
        bit   enq, deq;
        ent_t e;
        enq = in_valid && (mq.size() != DEPTH);
        deq = (mq.size() != 0) && out_ready;
        e.ins = in_instruction;
        e.imm = in_immediate;
        e.pc  = in_pc;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back(e);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] imm,
                         input logic [63:0] pc, input logic rdy, input logic fl);
        in_valid       = v;
        in_instruction = ins;
        in_immediate   = imm;
        in_pc          = pc;
        out_ready      = rdy;
        flush          = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[6:0] = 7'h63;
            1: r[1:0] = 2'b00;
            default: r[1:0] = 2'b11;
        endcase
        return r;
    endfunction

    initial begin
        drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        check_all("post_reset");

        // Single pass with one-cycle visibility latency.
        drive(1'b1, 32'h00500093, 64'd5, 64'd0, 1'b0, 1'b0);
        cycle("single_enq");
        check_eq("single.pc_visible", 64'(out_valid), 64'h1);
        drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0);
        cycle("single_deq");
        check_eq("single.count_zero", 64'(count), 64'h0);

        // Fill and backpressure: third entry held by fetch while full.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00000013, 64'(i), 64'(4 * i), 1'b0, 1'b0);
            cycle("fill");
        end
        check_eq("fill.in_ready_low", 64'(in_ready), 64'h0);
        check_eq("fill.head_pc_stable", out_pc, 64'h0);

        // Drain, then stream with wrap.
        drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0);
        cycle("drain");
        cycle("drain");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h00000013, 64'(i), 64'(4 * i), 1'b1, 1'b0);
            cycle("stream");
        end
        check_eq("stream.count_settled", 64'(count), 64'h1);
        check_eq("stream.last_pc", out_pc, 64'd36);
        drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0);
        cycle("stream_drain");

        // Branch and illegal tagging.
        drive(1'b1, 32'hFE000EE3, 64'h0, 64'h100, 1'b0, 1'b0);
        cycle("tag_a");
        check_eq("tag.branch_first", 64'(out_is_branch), 64'h1);
        check_eq("tag.legal_first", 64'(out_illegal), 64'h0);
        drive(1'b1, 32'h00000000, 64'h0, 64'h104, 1'b1, 1'b0);
        cycle("tag_b");
        check_eq("tag.branch_second", 64'(out_is_branch), 64'h0);
        check_eq("tag.illegal_second", 64'(out_illegal), 64'h1);

        // Fill, then flush colliding with enqueue and dequeue.
        drive(1'b1, 32'h00000013, 64'h0, 64'h200, 1'b0, 1'b0);
        cycle("flush_fill");
        check_eq("flush.full", 64'(count), 64'd2);
        drive(1'b1, 32'h00000013, 64'h0, 64'h300, 1'b1, 1'b1);
        cycle("flush");
        check_eq("flush.count", 64'(count), 64'h0);
        check_eq("flush.out_valid", 64'(out_valid), 64'h0);
        check_eq("flush.in_ready", 64'(in_ready), 64'h1);

        // Reset mid-operation with two entries queued.
        drive(1'b1, 32'h00100093, 64'h1, 64'h400, 1'b0, 1'b0);
        cycle("pre_reset");
        cycle("pre_reset");
        check_eq("pre_reset.count", 64'(count), 64'd2);
        drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        mq.delete();
        check_all("async_reset");
        #2;
        reset = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
                  64'(4 * i), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
